pc_retire_monitor: RTL and testbench
====================================

// Module: pc_retire_monitor
// PURPOSE
//   Synthesizable run-control monitor for xgriscv_pipeline. Watches the writeback PC
//   (pcW) and its retire strobe, and counts cycles and retired instructions.
//   Ends a run on a programmable end address, a PC hang, or a cycle timeout.
//   Flags NUM_BP address breakpoints; benches and the FPGA top share one end-of-run criterion.
// PARAMETERS
//   ADDR_SIZE    32    width of pcW, end_addr and each breakpoint address
//   NUM_BP       4     number of breakpoint channels (1..16)
//   CNT_W        32    width of cycle_cnt, retire_cnt and cfg_timeout
//   STALL_LIMIT  1024  consecutive RUN cycles without a new retired PC before declaring HANG
// PORTS
//   clk          in   1                 clock; all state updates on rising edge
//   rstn         in   1                 synchronous active-low reset
//   start        in   1                 IDLE->RUN request (level; sampled in IDLE only)
//   clear        in   1                 DONE->IDLE; also clears bp_hit
//   pcW          in   ADDR_SIZE         writeback-stage PC
//   pcW_valid    in   1                 an instruction retires at pcW this cycle
//   end_addr     in   ADDR_SIZE         address whose retirement ends the run
//   cfg_timeout  in   CNT_W             cycle budget; 0 = no timeout
//   bp_addr      in   NUM_BP*ADDR_SIZE  breakpoint i at [i*ADDR_SIZE +: ADDR_SIZE]
//   bp_en        in   NUM_BP            per-channel breakpoint enable
//   running      out  1                 state == RUN
//   done         out  1                 state == DONE
//   done_cause   out  2                 00 none, 01 END, 10 HANG, 11 TIMEOUT
//   cycle_cnt    out  CNT_W             RUN cycles elapsed
//   retire_cnt   out  CNT_W             retirements counted in RUN
//   bp_hit       out  NUM_BP            sticky per-channel hit flags
//   bp_pulse     out  NUM_BP            one-cycle hit pulse, registered
// BEHAVIOUR
//   - Reset (rstn=0 at an edge, any state, mid-run included): state=IDLE, done_cause=0,
//     all counters, bp_hit, bp_pulse, stall_cnt, last_pc=0. All outputs are registered.
//   - FSM IDLE->RUN when start=1; the counters are zeroed on that edge.
//     RUN->DONE on a termination event. DONE->IDLE when clear=1.
//     start is ignored outside IDLE; clear is ignored outside DONE.
//   - In RUN, each edge:
//     - cycle_cnt += 1.
//     - retire_cnt += 1 if pcW_valid.
//     - Both counters saturate at all-ones; they never wrap.
//   - Stall tracking: pcW_valid && pcW != last_pc -> stall_cnt=0 and last_pc=pcW.
//     Otherwise stall_cnt += 1. A self-loop (jal x0,0) therefore counts as a stall.
//   - Termination events, evaluated on the RUN cycle's inputs:
//     - END: pcW_valid && pcW==end_addr.
//     - HANG: stall_cnt == STALL_LIMIT-1 and no new PC this cycle.
//     - TIMEOUT: cfg_timeout!=0 && cycle_cnt == cfg_timeout-1.
//     - Priority when simultaneous: END > HANG > TIMEOUT. Only the winner is encoded.
//   - Latency: done and done_cause rise on the edge that samples the event (1 cycle).
//     cycle_cnt includes that final cycle. The terminating retirement is counted in retire_cnt.
//   - DONE holds cycle_cnt, retire_cnt and done_cause stable until clear or reset.
//     clear zeroes done_cause and bp_hit only; the counters keep their values until the next start.
//   - Breakpoints, RUN only:
//     - Hit i = pcW_valid && bp_en[i] && pcW==bp_addr[i].
//     - bp_pulse[i] is 1 for exactly the next cycle per hit; bp_hit[i] is set and stays set.
//     - Several channels may hit in one cycle. A hit does not stop the run.
//   - Inputs in IDLE/DONE do not alter counters, stall state or breakpoint flags.
// TESTING
//   1 reset, start, 30 retires at pcW=0,4,..,0x74 then 0x78, end_addr=0x78
//     -> done=1, cause=01, retire_cnt=31, cycle_cnt=31.
//   2 run, then pcW held at 0x40 with valid each cycle, STALL_LIMIT=16
//     -> cause=10 exactly 16 cycles after the first repeat.
//   3 cfg_timeout=100, no end retired -> done on the 100th RUN edge, cycle_cnt=100, cause=11.
//   4 bp_addr0=0x10, bp_addr2=0x10, bp_en=0101, retire 0x10
//     -> bp_pulse=0101 for 1 cycle, bp_hit=0101 sticky.
//   5 end retire and timeout on the same cycle -> cause=01.
//     A clear in DONE -> IDLE with the counters held.
//   6 rstn=0 mid-run with the counters nonzero -> next cycle: all outputs zero, running=0.

Source files
------------

// File: rtl/pc_retire_monitor.sv
// pc_retire_monitor: run-control monitor on the writeback PC; counts cycles/retires,
// ends a run on end address, PC hang or cycle timeout, and flags address breakpoints.
module pc_retire_monitor #(
  parameter int ADDR_SIZE   = 32,
  parameter int NUM_BP      = 4,
  parameter int CNT_W       = 32,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      clear,
  input  logic [ADDR_SIZE-1:0]      pcW,
  input  logic                      pcW_valid,
  input  logic [ADDR_SIZE-1:0]      end_addr,
  input  logic [CNT_W-1:0]          cfg_timeout,
  input  logic [NUM_BP*ADDR_SIZE-1:0] bp_addr,
  input  logic [NUM_BP-1:0]         bp_en,
  output logic                      running,
  output logic                      done,
  output logic [1:0]                done_cause,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic [NUM_BP-1:0]         bp_hit,
  output logic [NUM_BP-1:0]         bp_pulse
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SW = $clog2(STALL_LIMIT + 1);
  state_t                state_q, state_d;
  logic [1:0]            cause_q, cause_d;
  logic [CNT_W-1:0]      cyc_q, cyc_d, ret_q, ret_d;
  logic [SW-1:0]         stall_q, stall_d;
  logic [ADDR_SIZE-1:0]  last_pc_q, last_pc_d;
  logic [NUM_BP-1:0]     hit_q, hit_d, pulse_q, pulse_d, bp_match;
  logic                  new_pc, end_ev, hang_ev, to_ev;
  always_comb begin
    for (int i = 0; i < NUM_BP; i++)
      bp_match[i] = pcW_valid && bp_en[i] && pcW == bp_addr[i*ADDR_SIZE +: ADDR_SIZE];
    new_pc  = pcW_valid && pcW != last_pc_q;
    end_ev  = pcW_valid && pcW == end_addr;
    hang_ev = stall_q == SW'(STALL_LIMIT - 1) && !new_pc;
    to_ev   = cfg_timeout != '0 && cyc_q == cfg_timeout - CNT_W'(1);
    state_d   = state_q;
    cause_d   = cause_q;
    cyc_d     = cyc_q;
    ret_d     = ret_q;
    stall_d   = stall_q;
    last_pc_d = last_pc_q;
    hit_d     = hit_q;
    pulse_d   = '0;
    case (state_q)
      IDLE: if (start) begin
        state_d   = RUN;
        cyc_d     = '0;
        ret_d     = '0;
        stall_d   = '0;
        last_pc_d = '0;
      end
      RUN: begin
        cyc_d     = &cyc_q ? cyc_q : cyc_q + CNT_W'(1);
        ret_d     = pcW_valid && !(&ret_q) ? ret_q + CNT_W'(1) : ret_q;
        stall_d   = new_pc ? '0 : stall_q + SW'(1);
        last_pc_d = new_pc ? pcW : last_pc_q;
        hit_d     = hit_q | bp_match;
        pulse_d   = bp_match;
        if (end_ev || hang_ev || to_ev) begin
          state_d = DONE;
          cause_d = end_ev ? 2'b01 : hang_ev ? 2'b10 : 2'b11;
        end
      end
      default: if (clear) begin
        state_d = IDLE;
        cause_d = '0;
        hit_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      cyc_q     <= '0;
      ret_q     <= '0;
      stall_q   <= '0;
      last_pc_q <= '0;
      hit_q     <= '0;
      pulse_q   <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      cyc_q     <= cyc_d;
      ret_q     <= ret_d;
      stall_q   <= stall_d;
      last_pc_q <= last_pc_d;
      hit_q     <= hit_d;
      pulse_q   <= pulse_d;
    end
  end
  assign running    = state_q == RUN;
  assign done       = state_q == DONE;
  assign done_cause = cause_q;
  assign cycle_cnt  = cyc_q;
  assign retire_cnt = ret_q;
  assign bp_hit     = hit_q;
  assign bp_pulse   = pulse_q;
endmodule

// File: tb/tb_pc_retire_monitor.sv
// tb_pc_retire_monitor: directed vectors with hand-computed expectations for pc_retire_monitor.
module tb_pc_retire_monitor;
  logic         clk = 1'b0;
  logic         rstn, start, clear, pcW_valid;
  logic [31:0]  pcW, end_addr, cfg_timeout, cycle_cnt, retire_cnt;
  logic [127:0] bp_addr;
  logic [3:0]   bp_en, bp_hit, bp_pulse;
  logic         running, done;
  logic [1:0]   done_cause;
  int           checks = 0;
  int           failures = 0;
  pc_retire_monitor #(.ADDR_SIZE(32), .NUM_BP(4), .CNT_W(32), .STALL_LIMIT(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .clear(clear), .pcW(pcW), .pcW_valid(pcW_valid),
    .end_addr(end_addr), .cfg_timeout(cfg_timeout), .bp_addr(bp_addr), .bp_en(bp_en),
    .running(running), .done(done), .done_cause(done_cause), .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt), .bp_hit(bp_hit), .bp_pulse(bp_pulse)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic retire(input logic [31:0] pc);
    pcW = pc;
    pcW_valid = 1'b1;
    step();
  endtask
  task automatic go();
    pcW_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic do_clear();
    pcW_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask
  initial begin
    rstn = 1'b0; start = 1'b0; clear = 1'b0; pcW = '0; pcW_valid = 1'b0;
    end_addr = 32'h78; cfg_timeout = '0; bp_addr = '0; bp_en = '0;
    step(); step();
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_cycle", cycle_cnt, 0);
    rstn = 1'b1;
    // 1: end address reached after 31 retirements
    go();
    check("t1_running", running, 1);
    for (int i = 0; i < 30; i++) retire(32'(i * 4));
    check("t1_not_done", done, 0);
    check("t1_retire_mid", retire_cnt, 30);
    retire(32'h78);
    check("t1_done", done, 1);
    check("t1_cause", done_cause, 2'b01);
    check("t1_retire", retire_cnt, 31);
    check("t1_cycle", cycle_cnt, 31);
    start = 1'b1;
    retire(32'h200);
    start = 1'b0;
    check("t1_hold_done", done, 1);
    check("t1_hold_cycle", cycle_cnt, 31);
    check("t1_hold_retire", retire_cnt, 31);
    do_clear();
    check("t1_clear_idle", done, 0);
    check("t1_clear_cause", done_cause, 0);
    // 2: PC stuck at 0x40 -> HANG on the 16th repeated retirement
    end_addr = 32'hFFFF_FFFC;
    go();
    retire(32'h40);
    for (int i = 0; i < 15; i++) retire(32'h40);
    check("t2_not_yet", done, 0);
    retire(32'h40);
    check("t2_done", done, 1);
    check("t2_cause", done_cause, 2'b10);
    check("t2_cycle", cycle_cnt, 17);
    do_clear();
    // 3: timeout of 100 cycles, fresh PC every cycle
    cfg_timeout = 100;
    go();
    for (int i = 0; i < 99; i++) retire(32'h1000 + 32'(i * 4));
    check("t3_not_yet", done, 0);
    check("t3_cycle_99", cycle_cnt, 99);
    retire(32'h2000);
    check("t3_done", done, 1);
    check("t3_cause", done_cause, 2'b11);
    check("t3_cycle", cycle_cnt, 100);
    check("t3_retire", retire_cnt, 100);
    do_clear();
    // 4: breakpoints on channels 0 and 2; channel 3 matches but is disabled
    cfg_timeout = 0; end_addr = 32'h18;
    bp_addr = {32'h10, 32'h10, 32'h20, 32'h10};
    bp_en = 4'b0101;
    go();
    retire(32'h0C);
    check("t4_no_pulse", bp_pulse, 0);
    retire(32'h10);
    check("t4_pulse", bp_pulse, 4'b0101);
    check("t4_hit", bp_hit, 4'b0101);
    check("t4_running", running, 1);
    retire(32'h20);
    check("t4_pulse_gone", bp_pulse, 0);
    check("t4_hit_sticky", bp_hit, 4'b0101);
    retire(32'h18);
    check("t4_end", done_cause, 2'b01);
    check("t4_hit_done", bp_hit, 4'b0101);
    do_clear();
    check("t4_hit_clr", bp_hit, 0);
    bp_en = '0;
    // 5: END and TIMEOUT together -> END wins; clear keeps counters
    cfg_timeout = 3; end_addr = 32'h8;
    go();
    retire(32'h0);
    retire(32'h4);
    retire(32'h8);
    check("t5_cause", done_cause, 2'b01);
    check("t5_cycle", cycle_cnt, 3);
    do_clear();
    check("t5_idle_run", running, 0);
    check("t5_idle_done", done, 0);
    check("t5_held_cycle", cycle_cnt, 3);
    check("t5_held_retire", retire_cnt, 3);
    // 6: reset mid-run clears everything
    cfg_timeout = 0; end_addr = 32'hFFFF_FFFC; bp_en = 4'b0001; bp_addr = {96'h0, 32'h100};
    go();
    retire(32'h100);
    retire(32'h104);
    check("t6_pre_retire", retire_cnt, 2);
    check("t6_pre_hit", bp_hit, 4'b0001);
    rstn = 1'b0;
    pcW_valid = 1'b0;
    step();
    check("t6_running", running, 0);
    check("t6_done", done, 0);
    check("t6_cycle", cycle_cnt, 0);
    check("t6_retire", retire_cnt, 0);
    check("t6_hit", bp_hit, 0);
    check("t6_pulse", bp_pulse, 0);
    check("t6_cause", done_cause, 0);
    rstn = 1'b1;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
